ahb_dma_src_fifo: RTL and testbench
===================================

Name: ahb_dma_src_fifo

Overview:
- DMA source peripheral: the responder on the AHB-Lite read side and the requester on the DmacReq/ReqAck side of the DMA controller.
- A local producer pushes 32-bit words into an internal FIFO. The block raises DmacReq once the fill level reaches a threshold.
- The DMAC then drains the FIFO through AHB-Lite reads of the data register.
- It replaces the ideal zero-wait memory model as a realistic source: wait states on empty, ERROR responses on illegal access.

Parameters:
DEPTH, 16, FIFO entries (power of two, >=2)
REQ_THRESH, 4, fill level at or above which DmacReq asserts (1..DEPTH)
MAX_WAIT, 8, maximum wait states on an empty-FIFO data read before an ERROR response

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
push_valid  in  1  producer word valid
push_data  in  32  producer word
push_ready  out  1  FIFO not full; a push occurs when push_valid & push_ready
HSEL  in  1  slave select
HADDR  in  32  address (only [3:2] decoded)
HTRANS  in  2  IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
HWRITE  in  1  write strobe
HREADY  in  1  bus ready (transfer qualifier)
HWDATA  in  32  write data (ignored)
HRDATA  out  32  read data
HREADYOUT  out  1  slave ready
HRESP  out  2  OKAY=2'b00, ERROR=2'b01
DmacReq  out  1  DMA request to controller
ReqAck  in  1  acknowledge from controller
level  out  $clog2(DEPTH)+1  current FIFO fill count

Behaviour:
- Reset (async, rst high): FIFO pointers and level = 0, HREADYOUT=1, HRESP=00, HRDATA=0, DmacReq=0, push_ready=1. Assertion mid-transfer aborts any data phase immediately; no partial pop.
- Address phase accepted when HSEL & HREADY & HTRANS[1]. Capture HWRITE and HADDR[3:2] into data-phase registers. IDLE/BUSY or unselected transfers give a zero-wait OKAY data phase.
- Register map (HADDR[3:2]):
  - 0 = DATA (read pops FIFO).
  - 1 = STATUS: {14'b0, empty[17], full[16], 16-bit zero-extended level[15:0]}.
  - 2,3 = read-as-zero, OKAY.
- Data-phase FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: read of DATA with FIFO non-empty → HREADYOUT=1, HRESP=OKAY, HRDATA=FIFO head, pop at the same clock edge (zero wait state).
  - IDLE: read of DATA with FIFO empty → enter WAIT.
  - WAIT: HREADYOUT=0, wait counter increments each cycle. A word arriving (level>0) completes the read in the following cycle with that word and pops it. Counter reaching MAX_WAIT with FIFO still empty → ERR1.
  - Any write (HWRITE=1) to any address → ERR1.
  - ERR1: HREADYOUT=0, HRESP=ERROR → ERR2.
  - ERR2: HREADYOUT=1, HRESP=ERROR → IDLE. No pop occurs on any ERROR response.
- HRDATA holds its last value outside completing read data phases.
- Pop occurs only in the cycle HREADYOUT=1 completes a DATA read with OKAY.
- Push and pop in the same cycle: both take effect and level is unchanged. When full, push_ready=0 even if a pop happens that cycle (push_ready is derived from the registered level). Pointers wrap modulo DEPTH.
- DmacReq handshake (four-phase):
  - Asserts the cycle after level >= REQ_THRESH while disarmed-free.
  - Stays high until ReqAck is sampled high, then drops the next cycle and the block is disarmed.
  - Rearms only after ReqAck is sampled low. Reasserts if level is still >= REQ_THRESH.
  - ReqAck high while DmacReq is low is ignored.

Test Plan:
- Push 4 words (0xAABBCCDD, 0x11223344, 0x55667788, 0x99AABBCC) → DmacReq=1 one cycle after level=4. Four NONSEQ/SEQ DATA reads return the words in order with zero wait; level returns to 0.
- Handshake: hold ReqAck=1 two cycles after DmacReq rises → DmacReq=0 the following cycle. With level still 6, DmacReq stays 0 until ReqAck=0, then reasserts next cycle.
- Empty read: DATA read with level 0, push 0x123 after 3 wait cycles → HREADYOUT low for 4 cycles, then HRDATA=0x123, OKAY. With no push → 8 wait cycles, then a two-cycle ERROR and level stays 0.
- Write to DATA with HWDATA=0xDEAD → ERR1 (HREADYOUT=0, HRESP=01), then ERR2 (HREADYOUT=1, HRESP=01). FIFO contents unchanged.
- Fill 16 words → push_ready=0 and STATUS read = 0x0001_0010. Simultaneous push and DATA read at full → push rejected, level=15. Pointer wrap verified by pushing/popping 40 words in sequence with data checked.
- Assert rst during WAIT → HREADYOUT=1, HRESP=00, DmacReq=0, level=0 asynchronously before the next clock edge.

Source files
------------

// File: rtl/ahb_dma_src_fifo.sv
// DMA source peripheral: producer-fed FIFO drained by AHB-Lite reads of a DATA register,
// with empty-read wait states, ERROR responses and a four-phase DmacReq/ReqAck handshake.
module ahb_dma_src_fifo #(
  parameter int DEPTH      = 16,
  parameter int REQ_THRESH = 4,
  parameter int MAX_WAIT   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_valid,
  input  logic [31:0]            push_data,
  output logic                   push_ready,
  input  logic                   HSEL,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic                   HREADY,
  input  logic [31:0]            HWDATA,
  output logic [31:0]            HRDATA,
  output logic                   HREADYOUT,
  output logic [1:0]             HRESP,
  output logic                   DmacReq,
  input  logic                   ReqAck,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0] level_reg;
  state_t        state_reg;
  logic [WW-1:0] wait_cnt_reg;
  logic          hready_reg;
  logic [1:0]    hresp_reg;
  logic [31:0]   hrdata_reg;
  logic          req_reg, armed_reg;

  logic fifo_empty, fifo_full, push_fire, pop_fire;
  logic accept, rd_data_now, rd_status, rd_raz, wait_done;
  logic [31:0] status_word;
  logic unused_bits;

  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HWDATA, HTRANS[0]};

  assign fifo_empty = (level_reg == '0);
  assign fifo_full  = (level_reg == LW'(DEPTH));
  assign push_fire  = push_valid & ~fifo_full;

  // New address phases are only taken while the current data phase is completing.
  assign accept      = HSEL & HREADY & HTRANS[1] & hready_reg;
  assign rd_data_now = accept & ~HWRITE & (HADDR[3:2] == 2'd0) & ~fifo_empty;
  assign rd_status   = accept & ~HWRITE & (HADDR[3:2] == 2'd1);
  assign rd_raz      = accept & ~HWRITE & HADDR[3];
  assign wait_done   = (state_reg == ST_WAIT) & ~fifo_empty;
  assign pop_fire    = rd_data_now | wait_done;
  assign status_word = {14'b0, fifo_empty, fifo_full, 16'(level_reg)};

  always_ff @(posedge clk) begin
    if (push_fire) mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push_fire) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop_fire)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push_fire, pop_fire})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Read data is loaded at the edge that opens the completing data phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hrdata_reg <= '0;
    end else if (pop_fire) begin
      hrdata_reg <= mem[rd_ptr_reg];
    end else if (rd_status) begin
      hrdata_reg <= status_word;
    end else if (rd_raz) begin
      hrdata_reg <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      hready_reg   <= 1'b1;
      hresp_reg    <= RESP_OKAY;
      wait_cnt_reg <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_ERR2: begin
          state_reg  <= ST_IDLE;
          hready_reg <= 1'b1;
          hresp_reg  <= RESP_OKAY;
          if (accept && HWRITE) begin
            state_reg  <= ST_ERR1;
            hready_reg <= 1'b0;
            hresp_reg  <= RESP_ERROR;
          end else if (accept && (HADDR[3:2] == 2'd0) && fifo_empty) begin
            state_reg    <= ST_WAIT;
            hready_reg   <= 1'b0;
            wait_cnt_reg <= '0;
          end
        end
        ST_WAIT: begin
          if (!fifo_empty) begin
            state_reg  <= ST_IDLE;
            hready_reg <= 1'b1;
          end else if (wait_cnt_reg == WW'(MAX_WAIT - 1)) begin
            state_reg <= ST_ERR1;
            hresp_reg <= RESP_ERROR;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
          end
        end
        default: begin
          state_reg  <= ST_ERR2;
          hready_reg <= 1'b1;
          hresp_reg  <= RESP_ERROR;
        end
      endcase
    end
  end

  // armed_reg clears on an acknowledged request and sets again once ReqAck is seen low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_reg   <= 1'b0;
      armed_reg <= 1'b1;
    end else if (req_reg) begin
      if (ReqAck) begin
        req_reg   <= 1'b0;
        armed_reg <= 1'b0;
      end
    end else begin
      if (!armed_reg && !ReqAck) armed_reg <= 1'b1;
      if ((armed_reg || !ReqAck) && (level_reg >= LW'(REQ_THRESH))) req_reg <= 1'b1;
    end
  end

  assign push_ready = ~fifo_full;
  assign HRDATA     = hrdata_reg;
  assign HREADYOUT  = hready_reg;
  assign HRESP      = hresp_reg;
  assign DmacReq    = req_reg;
  assign level      = level_reg;

endmodule

// File: tb/tb_ahb_dma_src_fifo.sv
// Randomized and directed bench for ahb_dma_src_fifo, checked every cycle against a
// queue-based behavioural model, plus hand-computed literal expectations.
module tb_ahb_dma_src_fifo;
  localparam int DEPTH = 16;
  localparam int REQ_THRESH = 4;
  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst, push_valid, push_ready;
  logic [31:0] push_data;
  logic        HSEL, HWRITE, HREADY, HREADYOUT, DmacReq, ReqAck;
  logic [31:0] HADDR, HWDATA, HRDATA;
  logic [1:0]  HTRANS, HRESP;
  logic [4:0]  level;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;
  bit verbose = 1;

  always #5 clk = ~clk;

  ahb_dma_src_fifo #(.DEPTH(DEPTH), .REQ_THRESH(REQ_THRESH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HREADY(HREADY),
    .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
    .DmacReq(DmacReq), .ReqAck(ReqAck), .level(level)
  );

  // ---------------- behavioural model ----------------
  logic [31:0] q[$];
  bit          m_ready, m_req, m_blocked, m_waiting, m_rd_done;
  logic [1:0]  m_resp;
  logic [31:0] m_rdata;
  int          m_waits;

  always @(posedge clk or posedge rst) begin
    int L;
    bit do_pop, do_push;
    if (rst) begin
      q.delete();
      m_ready = 1; m_resp = 2'b00; m_rdata = '0;
      m_req = 0; m_blocked = 0; m_waiting = 0; m_waits = 0; m_rd_done = 0;
    end else begin
      L = q.size();
      do_pop = 0;
      do_push = push_valid && (L < DEPTH);
      m_rd_done = 0;
      if (m_waiting) begin
        if (L > 0) begin
          do_pop = 1; m_rdata = q[0]; m_ready = 1; m_waiting = 0; m_rd_done = 1;
        end else if (m_waits == MAX_WAIT) begin
          m_waiting = 0; m_resp = 2'b01;
        end else begin
          m_waits++;
        end
      end else if (!m_ready) begin
        m_ready = 1;  // second cycle of an ERROR response
      end else begin
        m_resp = 2'b00;
        if (HSEL && HREADY && HTRANS[1]) begin
          if (HWRITE) begin
            m_ready = 0; m_resp = 2'b01;
          end else begin
            case (HADDR[3:2])
              2'd0: begin
                if (L > 0) begin
                  do_pop = 1; m_rdata = q[0]; m_rd_done = 1;
                end else begin
                  m_ready = 0; m_waiting = 1; m_waits = 1;
                end
              end
              2'd1: m_rdata = {14'b0, L == 0, L == DEPTH, 16'(L)};
              default: m_rdata = '0;
            endcase
          end
        end
      end
      if (m_req) begin
        if (ReqAck) begin m_req = 0; m_blocked = 1; end
      end else begin
        if ((!m_blocked || !ReqAck) && L >= REQ_THRESH) m_req = 1;
        if (!ReqAck) m_blocked = 0;
      end
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(push_data);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("HREADYOUT", 32'(HREADYOUT), 32'(m_ready));
      check("HRESP", 32'(HRESP), 32'(m_resp));
      check("HRDATA", HRDATA, m_rdata);
      check("DmacReq", 32'(DmacReq), 32'(m_req));
      check("level", 32'(level), 32'(q.size()));
      check("push_ready", 32'(push_ready), 32'(q.size() < DEPTH));
      if (verbose && m_rd_done)
        $display("txn: DATA read -> %h, level %0d", HRDATA, level);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    HREADY = HREADYOUT;
  endtask

  task automatic idle_bus();
    HSEL = 0; HTRANS = 2'b00; HWRITE = 0;
  endtask

  task automatic addr(input logic wr, input logic [1:0] a, input logic [1:0] tr);
    HSEL = 1; HTRANS = tr; HWRITE = wr;
    HADDR = $urandom();
    HADDR[3:2] = a;
  endtask

  task automatic drain();
    int n;
    n = 0;
    push_valid = 0;
    while (level != 0 && n < 200) begin
      addr(0, 2'd0, 2'b10);
      step();
      n++;
    end
    idle_bus();
    step();
    check("drain_level", 32'(level), 32'd0);
  endtask

  logic [31:0] words [4];
  int lowcnt;

  initial begin
    words[0] = 32'hAABBCCDD; words[1] = 32'h11223344;
    words[2] = 32'h55667788; words[3] = 32'h99AABBCC;
    rst = 0; push_valid = 0; push_data = '0; ReqAck = 0; HWDATA = '0; HADDR = '0;
    HREADY = 1; idle_bus();
    #1 rst = 1;
    repeat (3) @(negedge clk);
    rst = 0;
    chk_en = 1;
    check("rst_HREADYOUT", 32'(HREADYOUT), 32'd1);
    check("rst_HRESP", 32'(HRESP), 32'd0);
    check("rst_HRDATA", HRDATA, 32'd0);
    check("rst_DmacReq", 32'(DmacReq), 32'd0);
    check("rst_push_ready", 32'(push_ready), 32'd1);
    check("rst_level", 32'(level), 32'd0);

    // Four pushes, request one cycle after level reaches 4, then zero-wait burst reads
    for (int i = 0; i < 4; i++) begin
      push_valid = 1; push_data = words[i]; step();
    end
    push_valid = 0;
    check("t1_level4", 32'(level), 32'd4);
    check("t1_req_not_yet", 32'(DmacReq), 32'd0);
    step();
    check("t1_req_up", 32'(DmacReq), 32'd1);
    for (int i = 0; i < 4; i++) begin
      addr(0, 2'd0, (i == 0) ? 2'b10 : 2'b11);
      step();
      check("t1_rdata", HRDATA, words[i]);
      check("t1_zero_wait", 32'(HREADYOUT), 32'd1);
    end
    idle_bus();
    check("t1_level0", 32'(level), 32'd0);
    ReqAck = 1; step();
    ReqAck = 0; step();

    // Handshake with level 6
    for (int i = 0; i < 6; i++) begin
      push_valid = 1; push_data = $urandom(); step();
    end
    push_valid = 0;
    check("t2_req_up", 32'(DmacReq), 32'd1);
    ReqAck = 1; step();
    check("t2_req_drop", 32'(DmacReq), 32'd0);
    step();
    check("t2_req_held_low", 32'(DmacReq), 32'd0);
    ReqAck = 0; step();
    check("t2_req_rearm", 32'(DmacReq), 32'd1);
    check("t2_level6", 32'(level), 32'd6);
    drain();

    // Empty read completed by a late push
    addr(0, 2'd0, 2'b10); step(); idle_bus();
    lowcnt = 0;
    while (HREADYOUT == 0 && lowcnt < 20) begin
      lowcnt++;
      push_valid = (lowcnt == 3); push_data = 32'h123;
      step();
    end
    push_valid = 0;
    check("t3_wait_cycles", 32'(lowcnt), 32'd4);
    check("t3_rdata", HRDATA, 32'h123);
    check("t3_okay", 32'(HRESP), 32'd0);

    // Empty read timing out into a two-cycle ERROR
    step();
    addr(0, 2'd0, 2'b10); step(); idle_bus();
    lowcnt = 0;
    while (HREADYOUT == 0 && HRESP == 2'b00 && lowcnt < 20) begin
      lowcnt++; step();
    end
    check("t3_timeout_waits", 32'(lowcnt), 32'd8);
    check("t3_err1_ready", 32'(HREADYOUT), 32'd0);
    check("t3_err1_resp", 32'(HRESP), 32'd1);
    step();
    check("t3_err2_ready", 32'(HREADYOUT), 32'd1);
    check("t3_err2_resp", 32'(HRESP), 32'd1);
    check("t3_level", 32'(level), 32'd0);

    // Write to DATA is an error and leaves the FIFO intact
    push_valid = 1; push_data = 32'hA1; step();
    push_data = 32'hA2; step();
    push_valid = 0;
    HWDATA = 32'hDEAD; addr(1, 2'd0, 2'b10); step(); idle_bus();
    check("t4_err1_ready", 32'(HREADYOUT), 32'd0);
    check("t4_err1_resp", 32'(HRESP), 32'd1);
    step();
    check("t4_err2_ready", 32'(HREADYOUT), 32'd1);
    check("t4_err2_resp", 32'(HRESP), 32'd1);
    check("t4_level", 32'(level), 32'd2);
    addr(0, 2'd0, 2'b10); step();
    check("t4_rd0", HRDATA, 32'hA1);
    addr(0, 2'd0, 2'b11); step();
    check("t4_rd1", HRDATA, 32'hA2);
    idle_bus(); step();

    // Fill to full, STATUS, push+pop at full, 40-word wrap stream
    for (int i = 0; i < 16; i++) begin
      push_valid = 1; push_data = 32'h5000 + 32'(i); step();
    end
    push_valid = 0;
    check("t5_full_ready", 32'(push_ready), 32'd0);
    addr(0, 2'd1, 2'b10); step(); idle_bus();
    check("t5_status", HRDATA, 32'h0001_0010);
    push_valid = 1; push_data = 32'hBAD; addr(0, 2'd0, 2'b10); step();
    push_valid = 0; idle_bus();
    check("t5_level15", 32'(level), 32'd15);
    check("t5_head", HRDATA, 32'h5000);
    for (int i = 0; i < 40; i++) begin
      push_valid = 1; push_data = 32'h1000 + 32'(i);
      addr(0, 2'd0, (i == 0) ? 2'b10 : 2'b11);
      step();
    end
    push_valid = 0; idle_bus();
    check("t5_wrap_last", HRDATA, 32'h1018);
    check("t5_wrap_level", 32'(level), 32'd15);
    drain();

    // Randomized traffic
    verbose = 0;
    for (int c = 0; c < 3000; c++) begin
      push_valid = ($urandom_range(0, 99) < ((c < 1500) ? 45 : 22));
      push_data = $urandom();
      ReqAck = ($urandom_range(0, 3) == 0);
      HSEL = ($urandom_range(0, 7) != 0);
      HTRANS = 2'($urandom_range(0, 3));
      HWRITE = ($urandom_range(0, 15) == 0);
      HWDATA = $urandom();
      HADDR = $urandom();
      HADDR[3:2] = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      step();
    end
    push_valid = 0; ReqAck = 0; idle_bus();
    repeat (12) step();
    verbose = 1;
    drain();

    // Asynchronous reset in the middle of a wait-state data phase
    for (int i = 0; i < 5; i++) begin
      push_valid = 1; push_data = $urandom(); step();
    end
    push_valid = 0;
    step();
    drain();
    check("t6_req_before", 32'(DmacReq), 32'd1);
    addr(0, 2'd0, 2'b10); step(); idle_bus(); step();
    check("t6_in_wait", 32'(HREADYOUT), 32'd0);
    #2 rst = 1;
    #1;
    check("t6_async_ready", 32'(HREADYOUT), 32'd1);
    check("t6_async_resp", 32'(HRESP), 32'd0);
    check("t6_async_req", 32'(DmacReq), 32'd0);
    check("t6_async_level", 32'(level), 32'd0);
    @(negedge clk);
    rst = 0;
    HREADY = HREADYOUT;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
